// File: rtl/enum_chan_seq_if.sv
// Handshake bundle between a sequencer block and the logic that drives it.
// The abort vector exists only when ENUM_CHAN_SEQ_ABORT_EN is defined.
// master = stimulus/controller side, slave = sequencer side.
interface enum_chan_seq_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 5
);
    logic [CHANNELS-1:0]       start;
    logic [CHANNELS-1:0]       ready;
`ifdef ENUM_CHAN_SEQ_ABORT_EN
    logic [CHANNELS-1:0]       abort;
`endif
    logic [CHANNELS*WIDTH-1:0] code;
    logic [CHANNELS-1:0]       valid;
    logic [CHANNELS-1:0]       busy;
    logic [CHANNELS-1:0]       done;

`ifdef ENUM_CHAN_SEQ_ABORT_EN
    modport master (output start, ready, abort, input code, valid, busy, done);
    modport slave  (input start, ready, abort, output code, valid, busy, done);
`else
    modport master (output start, ready, input code, valid, busy, done);
    modport slave  (input start, ready, output code, valid, busy, done);
`endif
endinterface

// File: rtl/enum_chan_seq.sv
// Per-channel sequencer IDLE->FIRST->SECOND->DONE->IDLE, HOLD accepted beats per active state.
// Latency: start to FIRST is one cycle; all outputs come straight from flops.
// Backpressure: a beat is valid&ready; with ready low the state and beat count hold indefinitely.
// Optional ENUM_CHAN_SEQ_ABORT_EN adds a per-channel abort that drops FIRST/SECOND back to IDLE.
module enum_chan_seq #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 5,
    parameter int HOLD     = 2
) (
    input  logic            clk,
    input  logic            rst,
    enum_chan_seq_if.slave  bus
);
    localparam int CW = $clog2(HOLD + 1);
    localparam logic [WIDTH-1:0] FIRST_CODE = WIDTH'(3'b111);
    localparam logic [CW-1:0]    LAST_BEAT  = CW'(HOLD - 1);

    // The state encoding is the output code itself, so code needs no decode.
    typedef enum logic [WIDTH-1:0] {
        IDLE   = {WIDTH{1'b0}},
        FIRST  = FIRST_CODE,
        SECOND = ~FIRST_CODE,
        DONE   = {WIDTH{1'b1}}
    } state_t;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        state_t        state_q;
        state_t        state_d;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          valid_q;
        logic          busy_q;
        logic          done_q;
        logic          beat;
        logic          abort_req;

        assign beat = valid_q & bus.ready[i];

`ifdef ENUM_CHAN_SEQ_ABORT_EN
        assign abort_req = bus.abort[i];
`else
        assign abort_req = 1'b0;
`endif

        // Next-state and beat counter; the counter restarts on every state change.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                IDLE: begin
                    if (bus.start[i]) begin
                        state_d = FIRST;
                        cnt_d   = '0;
                    end
                end
                FIRST: begin
                    if (abort_req) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (beat) begin
                        if (cnt_q == LAST_BEAT) begin
                            state_d = SECOND;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                SECOND: begin
                    if (abort_req) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (beat) begin
                        if (cnt_q == LAST_BEAT) begin
                            state_d = DONE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // State, counter and status flags; flags are registered from the next state.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                valid_q <= (state_d == FIRST) || (state_d == SECOND);
                busy_q  <= (state_d != IDLE);
                done_q  <= (state_d == DONE);
            end
        end

        assign bus.code[i*WIDTH +: WIDTH] = state_q;
        assign bus.valid[i]               = valid_q;
        assign bus.busy[i]                = busy_q;
        assign bus.done[i]                = done_q;
    end
endmodule

// File: tb/tb_enum_chan_seq.sv
// Directed bench for enum_chan_seq: table of per-cycle vectors plus hand-written
// sequences for independence, reset, the WIDTH=8/HOLD=3 build and optional abort.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_enum_chan_seq;
    logic clk;
    logic rst;

    enum_chan_seq_if #(.CHANNELS(4), .WIDTH(5)) bus_a ();
    enum_chan_seq_if #(.CHANNELS(1), .WIDTH(8)) bus_b ();

    enum_chan_seq #(.CHANNELS(4), .WIDTH(5), .HOLD(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    enum_chan_seq #(.CHANNELS(1), .WIDTH(8), .HOLD(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [3:0]  start;
        logic [3:0]  ready;
        logic [19:0] code;
        logic [3:0]  valid;
        logic [3:0]  busy;
        logic [3:0]  done;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] s, input logic [3:0] r);
        bus_a.start = s;
        bus_a.ready = r;
    endtask

    function automatic void add(input logic [3:0] s, input logic [3:0] r, input logic [19:0] c,
                                input logic [3:0] v, input logic [3:0] b, input logic [3:0] d);
        vec_t e;
        e.start = s; e.ready = r; e.code = c; e.valid = v; e.busy = b; e.done = d;
        vecs.push_back(e);
    endfunction

    initial begin
        int          first_done [4];
        int          n_done     [4];
        int          exp_first  [4];
        logic [3:0]  r;
        logic [7:0]  exp_b      [8];

        // Channel 0 straight through with ready held high.
        add(4'h1, 4'h1, 20'h00007, 4'h1, 4'h1, 4'h0);
        add(4'h0, 4'h1, 20'h00007, 4'h1, 4'h1, 4'h0);
        add(4'h0, 4'h1, 20'h00018, 4'h1, 4'h1, 4'h0);
        add(4'h0, 4'h1, 20'h00018, 4'h1, 4'h1, 4'h0);
        add(4'h0, 4'h1, 20'h0001F, 4'h0, 4'h1, 4'h1);
        add(4'h0, 4'h1, 20'h00000, 4'h0, 4'h0, 4'h0);
        // Channel 1 stalled five cycles in FIRST (start there ignored), then two beats.
        add(4'h2, 4'h0, 20'h000E0, 4'h2, 4'h2, 4'h0);
        add(4'h0, 4'h0, 20'h000E0, 4'h2, 4'h2, 4'h0);
        add(4'h2, 4'h0, 20'h000E0, 4'h2, 4'h2, 4'h0);
        add(4'h0, 4'h0, 20'h000E0, 4'h2, 4'h2, 4'h0);
        add(4'h0, 4'h0, 20'h000E0, 4'h2, 4'h2, 4'h0);
        add(4'h0, 4'h0, 20'h000E0, 4'h2, 4'h2, 4'h0);
        add(4'h0, 4'h2, 20'h000E0, 4'h2, 4'h2, 4'h0);
        add(4'h0, 4'h2, 20'h00300, 4'h2, 4'h2, 4'h0);
        add(4'h0, 4'h2, 20'h00300, 4'h2, 4'h2, 4'h0);
        add(4'h0, 4'h2, 20'h003E0, 4'h0, 4'h2, 4'h2);
        // Start while in DONE must not restart the channel.
        add(4'h2, 4'h0, 20'h00000, 4'h0, 4'h0, 4'h0);
        add(4'h0, 4'h0, 20'h00000, 4'h0, 4'h0, 4'h0);

        exp_b = '{8'h07, 8'h07, 8'h07, 8'hF8, 8'hF8, 8'hF8, 8'hFF, 8'h00};
        exp_first = '{4, 7, 6, 12};

        rst = 1'b1;
        drive(4'h0, 4'h0);
        bus_b.start = 1'b0;
        bus_b.ready = 1'b0;
`ifdef ENUM_CHAN_SEQ_ABORT_EN
        bus_a.abort = 4'h0;
        bus_b.abort = 1'b0;
`endif
        tick();
        tick();
        check("reset_code",  {12'd0, bus_a.code}, 32'h0);
        check("reset_valid", {28'd0, bus_a.valid}, 32'h0);
        check("reset_busy",  {28'd0, bus_a.busy},  32'h0);
        check("reset_done",  {28'd0, bus_a.done},  32'h0);
        check("reset_code_b", {24'd0, bus_b.code}, 32'h0);
        rst = 1'b0;
        tick();

        // Table-driven vectors.
        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].start, vecs[k].ready);
            tick();
            check($sformatf("vec%0d_code", k),  {12'd0, bus_a.code},  {12'd0, vecs[k].code});
            check($sformatf("vec%0d_valid", k), {28'd0, bus_a.valid}, {28'd0, vecs[k].valid});
            check($sformatf("vec%0d_busy", k),  {28'd0, bus_a.busy},  {28'd0, vecs[k].busy});
            check($sformatf("vec%0d_done", k),  {28'd0, bus_a.done},  {28'd0, vecs[k].done});
        end

        // All four channels started together with different ready patterns.
        for (int i = 0; i < 4; i++) begin
            first_done[i] = -1;
            n_done[i]     = 0;
        end
        drive(4'hF, 4'h0);
        tick();
        check("multi_start_code", {12'd0, bus_a.code}, 32'h00039CE7);
        for (int e = 1; e <= 15; e++) begin
            r[0] = 1'b1;
            r[1] = (e % 2) == 1;
            r[2] = e >= 3;
            r[3] = (e % 3) == 0;
            drive(4'h0, r);
            tick();
            for (int i = 0; i < 4; i++) begin
                if (bus_a.done[i]) begin
                    n_done[i]++;
                    if (first_done[i] < 0) first_done[i] = e;
                end
            end
            if (e == 5) begin
                check("multi_e5_code",  {12'd0, bus_a.code},  32'h0003E300);
                check("multi_e5_valid", {28'd0, bus_a.valid}, 32'hE);
            end
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("multi_done_cycle_ch%0d", i), first_done[i], exp_first[i]);
            check($sformatf("multi_done_count_ch%0d", i), n_done[i], 32'd1);
        end
        check("multi_end_busy", {28'd0, bus_a.busy}, 32'h0);

        // Reset while channel 2 is in SECOND.
        drive(4'h4, 4'h0);
        tick();
        drive(4'h0, 4'h4);
        tick();
        tick();
        check("ch2_second_code", {27'd0, bus_a.code[14:10]}, 32'h18);
        rst = 1'b1;
        tick();
        check("rst_ch2_code", {27'd0, bus_a.code[14:10]}, 32'h0);
        check("rst_ch2_busy", {31'd0, bus_a.busy[2]}, 32'h0);
        check("rst_ch2_done", {31'd0, bus_a.done[2]}, 32'h0);
        // Reset wins over a same-cycle start.
        drive(4'hF, 4'hF);
        tick();
        check("rst_vs_start_busy", {28'd0, bus_a.busy}, 32'h0);
        rst = 1'b0;
        drive(4'h0, 4'h0);
        tick();
        check("after_rst_busy", {28'd0, bus_a.busy}, 32'h0);

        // WIDTH=8, HOLD=3 instance: three beats in each active state.
        bus_b.start = 1'b1;
        bus_b.ready = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick();
            bus_b.start = 1'b0;
            check($sformatf("w8_code_e%0d", e), {24'd0, bus_b.code}, {24'd0, exp_b[e]});
            check($sformatf("w8_done_e%0d", e), {31'd0, bus_b.done}, {31'd0, (e == 6)});
        end
        bus_b.ready = 1'b0;

`ifdef ENUM_CHAN_SEQ_ABORT_EN
        // Abort on the completing beat of SECOND: back to IDLE, no done pulse.
        drive(4'h1, 4'h1);
        tick();
        drive(4'h0, 4'h1);
        tick();
        tick();
        tick();
        check("abort_pre_code", {27'd0, bus_a.code[4:0]}, 32'h18);
        bus_a.abort = 4'h1;
        tick();
        check("abort_code", {27'd0, bus_a.code[4:0]}, 32'h0);
        check("abort_done", {31'd0, bus_a.done[0]}, 32'h0);
        check("abort_busy", {31'd0, bus_a.busy[0]}, 32'h0);
        bus_a.abort = 4'h0;
        tick();
        check("abort_no_late_done", {31'd0, bus_a.done[0]}, 32'h0);
        // Abort in IDLE is ignored; abort in FIRST returns to IDLE.
        drive(4'h1, 4'h0);
        bus_a.abort = 4'h1;
        tick();
        check("abort_idle_ignored", {27'd0, bus_a.code[4:0]}, 32'h07);
        drive(4'h0, 4'h0);
        tick();
        check("abort_first_code", {27'd0, bus_a.code[4:0]}, 32'h0);
        bus_a.abort = 4'h0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/enum_chan_seq.md
ENUM_CHAN_SEQ -- requirements
Module: enum_chan_seq

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent sequencer channels (1..16).
REQ-002 SHALL have parameter WIDTH, default 5, bit width of each channel's enum code (4..16).
REQ-003 SHALL have parameter HOLD, default 2, accepted beats per active state (1..255).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  CHANNELS  per-channel start request, bit i drives channel i.
REQ-007 SHALL have port ready  input  CHANNELS  per-channel downstream ready.
REQ-008 SHALL have port code  output  CHANNELS*WIDTH  channel i enum code in bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port valid  output  CHANNELS  channel i code is a beat offered downstream.
REQ-010 SHALL have port busy  output  CHANNELS  channel i is not IDLE.
REQ-011 SHALL have port done  output  CHANNELS  one-cycle pulse, channel i sequence complete.

Function
REQ-012 SHALL implement per channel a registered enum FSM with states IDLE, FIRST, SECOND, DONE.
REQ-013 SHALL encode IDLE as all zeros, FIRST as low three bits set (WIDTH=5: 00111), SECOND as bitwise inverse of FIRST (11000), DONE as all ones.
REQ-014 SHALL drive code directly from the state register; no combinational decode onto outputs.
REQ-015 SHALL assert valid only in FIRST and SECOND; busy in FIRST, SECOND, DONE; done only in DONE.
REQ-016 SHALL count a beat when valid and ready are both high on a clock edge.
REQ-017 SHALL keep a per-channel beat counter (width clog2(HOLD+1)), cleared on every state change.
REQ-018 SHALL move IDLE -> FIRST on the edge where start is high; start latency one cycle.
REQ-019 SHALL move FIRST -> SECOND on the edge completing the HOLD-th beat in FIRST.
REQ-020 SHALL move SECOND -> DONE on the edge completing the HOLD-th beat in SECOND.
REQ-021 SHALL hold DONE exactly one cycle, then return to IDLE unconditionally.
REQ-022 SHALL ignore start in FIRST, SECOND and DONE; start in DONE does not restart.
REQ-023 SHALL hold state and counter while valid is high and ready low (no timeout).
REQ-024 SHALL keep channels fully independent; simultaneous events on different channels do not interact.

Reset
REQ-025 SHALL on rst high at a clock edge force every channel to IDLE, counter 0, regardless of state.
REQ-026 SHALL have reset values: code all zeros, valid 0, busy 0, done 0.
REQ-027 SHALL give rst priority over start, ready and abort in the same cycle.

Configuration
REQ-028 SHALL, when ENUM_CHAN_SEQ_ABORT_EN is defined, add port abort  input  CHANNELS.
REQ-029 SHALL, with the macro, move a channel from FIRST or SECOND to IDLE on abort, no done pulse, counter cleared; abort has priority over a same-cycle completing beat.
REQ-030 SHALL, with the macro, ignore abort in IDLE and DONE.
REQ-031 SHALL, without the macro, have no abort port; FIRST/SECOND exit only via REQ-019/020 or reset.

Verification
REQ-032 SHALL cover: defaults, start[0] pulse, ready=1 -> code[4:0] 00111 for 2 cycles, 11000 for 2, 11111 with done[0]=1 for 1, then 00000.
REQ-033 SHALL cover: ready[1]=0 for 5 cycles in FIRST -> code[9:5] stays 00111, valid[1]=1, counter frozen; advances after 2 beats once ready returns.
REQ-034 SHALL cover: start on all 4 channels same cycle, ready pattern differs per channel -> each channel's sequence independent, done pulses at differing cycles.
REQ-035 SHALL cover: rst asserted while channel 2 in SECOND -> next cycle code[14:10]=00000, busy[2]=0, done[2]=0.
REQ-036 SHALL cover: WIDTH=8, HOLD=3 -> FIRST 00000111, SECOND 11111000, 3 beats each.
REQ-037 SHALL cover, with ENUM_CHAN_SEQ_ABORT_EN: abort[0] on the completing beat in SECOND -> IDLE, no done pulse.
